// File: rtl/display_scan_controller.sv
// Digit scan and frame-stable value source for a 4-digit hex display.
// Loads land in a shadow register and reach binario only between frames.
module display_scan_controller #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic [15:0] binario,
  output logic [1:0]  selectorMUX,
  output logic        digit_blank,
  output logic        frame_tick
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [CW:0] BLANK_W = (CW + 1)'(BLANK_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   binario_q, binario_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic          load_ready_q, load_ready_d;
  logic          digit_blank_q, digit_blank_d;
  logic          frame_tick_q, frame_tick_d;
  logic          accept;
  logic          tick;
  logic          blank_hit;

  assign accept = load_valid & load_ready_q;
  assign tick   = (cnt_q == CNT_MAX);

  // Blank window only exists when at least one blank cycle is configured.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign blank_hit = 1'b0;
  end else begin : g_blank
    assign blank_hit = ({1'b0, cnt_d} < BLANK_W);
  end

  // Next-state: scan sequencing, frame-boundary transfer, load handshake.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    sel_d        = sel_q;
    binario_d    = binario_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    frame_tick_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending_q) begin
          binario_d = shadow_q;
          pending_d = 1'b0;
        end
        if (enable) state_d = SCAN;
      end
      SCAN: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          cnt_d = tick ? '0 : cnt_q + 1'b1;
          if (tick) begin
            sel_d = sel_q + 2'd1;
            if (sel_q == 2'd3) begin
              frame_tick_d = 1'b1;
              if (pending_q) begin
                binario_d = shadow_q;
                pending_d = 1'b0;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      shadow_d  = load_data;
      pending_d = 1'b1;
    end
    load_ready_d  = ~pending_q & ~accept;
    digit_blank_d = (state_d == IDLE) | blank_hit;
  end

  // State and output registers; reset drops any shadowed value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sel_q         <= 2'd0;
      binario_q     <= 16'h0000;
      shadow_q      <= 16'h0000;
      pending_q     <= 1'b0;
      load_ready_q  <= 1'b0;
      digit_blank_q <= 1'b1;
      frame_tick_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      binario_q     <= binario_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      load_ready_q  <= load_ready_d;
      digit_blank_q <= digit_blank_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign load_ready  = load_ready_q;
  assign binario     = binario_q;
  assign selectorMUX = sel_q;
  assign digit_blank = digit_blank_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller.
// Two instances: PRESCALE=4/BLANK=1 and PRESCALE=2/BLANK=0.
module tb_display_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0000;

  logic        rdy1, blk1, ft1;
  logic [15:0] bin1;
  logic [1:0]  sel1;
  logic        rdy2, blk2, ft2;
  logic [15:0] bin2;
  logic [1:0]  sel2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  display_scan_controller #(.PRESCALE(4), .BLANK_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .load_valid(load_valid), .load_data(load_data),
    .load_ready(rdy1), .binario(bin1), .selectorMUX(sel1),
    .digit_blank(blk1), .frame_tick(ft1)
  );

  display_scan_controller #(.PRESCALE(2), .BLANK_CYCLES(0)) u2 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .load_valid(load_valid), .load_data(load_data),
    .load_ready(rdy2), .binario(bin2), .selectorMUX(sel2),
    .digit_blank(blk2), .frame_tick(ft2)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    logic [20:0] got, exp;
    step(2);
    exp = {2'd0, 1'b1, 1'b0, 1'b0, 16'h0000};
    got = {sel1, blk1, ft1, rdy1, bin1};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL reset_u1 got=%h exp=%h", got, exp);
    end
    got = {sel2, blk2, ft2, rdy2, bin2};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL reset_u2 got=%h exp=%h", got, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_scan;
    logic [20:0] got, exp;
    for (int k = 0; k < 32; k++) begin
      step(1);
      exp = {2'((k / 4) % 4), (k % 4) == 0,
             (k % 16) == 0 && k > 0, 1'b1, 16'h0000};
      got = {sel1, blk1, ft1, rdy1, bin1};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL scan k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_load;
    step(5);
    load_valid = 1'b1;
    load_data = 16'hA3F1;
    step(1);
    n_cmp++;
    if ({rdy1, bin1} !== {1'b0, 16'h0000}) begin
      n_bad++;
      $display("FAIL load_accept got=%b/%h exp=0/0000", rdy1, bin1);
    end
    load_data = 16'h1234;
    step(10);
    n_cmp++;
    if ({rdy1, bin1} !== {1'b0, 16'h0000}) begin
      n_bad++;
      $display("FAIL load_hold got=%b/%h exp=0/0000", rdy1, bin1);
    end
    step(1);
    n_cmp++;
    if ({sel1, ft1, rdy1, bin1} !== {2'd0, 1'b1, 1'b0, 16'hA3F1}) begin
      n_bad++;
      $display("FAIL load_frame sel=%0d ft=%b rdy=%b bin=%h exp 0/1/0/a3f1",
               sel1, ft1, rdy1, bin1);
    end
    step(1);
    n_cmp++;
    if ({rdy1, bin1} !== {1'b1, 16'hA3F1}) begin
      n_bad++;
      $display("FAIL load_ready_back got=%b/%h exp=1/a3f1", rdy1, bin1);
    end
    step(1);
    n_cmp++;
    if (rdy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL second_accept rdy got=%b exp=0", rdy1);
    end
    load_valid = 1'b0;
    step(13);
    n_cmp++;
    if ({sel1, bin1} !== {2'd3, 16'hA3F1}) begin
      n_bad++;
      $display("FAIL second_wait got=%0d/%h exp=3/a3f1", sel1, bin1);
    end
    step(1);
    n_cmp++;
    if ({ft1, bin1} !== {1'b1, 16'h1234}) begin
      n_bad++;
      $display("FAIL second_show got=%b/%h exp=1/1234", ft1, bin1);
    end
    step(1);
    n_cmp++;
    if (rdy1 !== 1'b1) begin
      n_bad++;
      $display("FAIL second_ready got=%b exp=1", rdy1);
    end
  endtask

  task automatic test_idle;
    step(9);
    n_cmp++;
    if ({sel1, blk1} !== {2'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL pre_idle got=%0d/%b exp=2/0", sel1, blk1);
    end
    enable = 1'b0;
    step(1);
    n_cmp++;
    if ({sel1, blk1, ft1} !== {2'd2, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL idle_enter got=%0d/%b/%b exp=2/1/0", sel1, blk1, ft1);
    end
    load_valid = 1'b1;
    load_data = 16'h00FF;
    step(1);
    load_valid = 1'b0;
    n_cmp++;
    if ({rdy1, bin1} !== {1'b0, 16'h1234}) begin
      n_bad++;
      $display("FAIL idle_accept got=%b/%h exp=0/1234", rdy1, bin1);
    end
    step(1);
    n_cmp++;
    if ({sel1, blk1, bin1} !== {2'd2, 1'b1, 16'h00FF}) begin
      n_bad++;
      $display("FAIL idle_update got=%0d/%b/%h exp=2/1/00ff",
               sel1, blk1, bin1);
    end
    step(1);
    n_cmp++;
    if (rdy1 !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_ready got=%b exp=1", rdy1);
    end
    enable = 1'b1;
    step(1);
    n_cmp++;
    if ({sel1, blk1} !== {2'd2, 1'b1}) begin
      n_bad++;
      $display("FAIL resume_start got=%0d/%b exp=2/1", sel1, blk1);
    end
    step(3);
    n_cmp++;
    if ({sel1, blk1} !== {2'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL resume_slot got=%0d/%b exp=2/0", sel1, blk1);
    end
    step(1);
    n_cmp++;
    if ({sel1, blk1} !== {2'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL resume_next got=%0d/%b exp=3/1", sel1, blk1);
    end
  endtask

  task automatic test_async_reset;
    logic [20:0] got, exp;
    load_valid = 1'b1;
    load_data = 16'hBEEF;
    step(1);
    load_valid = 1'b0;
    n_cmp++;
    if (rdy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL pre_reset_accept got=%b exp=0", rdy1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp = {2'd0, 1'b1, 1'b0, 1'b0, 16'h0000};
    got = {sel1, blk1, ft1, rdy1, bin1};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL async_reset got=%h exp=%h", got, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    n_cmp++;
    if ({sel1, blk1, rdy1} !== {2'd0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL post_reset got=%0d/%b/%b exp=0/1/1", sel1, blk1, rdy1);
    end
    step(16);
    n_cmp++;
    if ({sel1, ft1, bin1} !== {2'd0, 1'b1, 16'h0000}) begin
      n_bad++;
      $display("FAIL discard got=%0d/%b/%h exp=0/1/0000", sel1, ft1, bin1);
    end
  endtask

  task automatic test_fast;
    logic [3:0] got, exp;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1);
      exp = {2'((k / 2) % 4), 1'b0, (k % 8) == 0 && k > 0};
      got = {sel2, blk2, ft2};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL fast k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_idle();
    test_async_reset();
    test_fast();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Upstream stage for the 4-digit hex display decoder. It produces the 2-bit digit selector at a multiplex rate set by a prescaler, and it supplies a 16-bit display value that changes only on frame boundaries, so the decoder never shows a half-updated number. A valid/ready load handshake accepts new values from the producer, such as a switch or counter block. An anti-ghosting blank window is asserted at the start of every digit slot.

Parameters:
PRESCALE, 50000, clk cycles per digit slot (50 MHz gives 1 kHz per digit and 250 Hz per frame); legal range >= 2
BLANK_CYCLES, 0, cycles at the start of each slot during which digit_blank=1; legal range 0 .. PRESCALE-1

Ports:
clk  in  1  system clock; all flops rise on this edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scanning runs; 0 = scanning halted, display blanked
load_valid  in  1  producer offers load_data
load_data  in  16  new display value; nibble [3:0] is digit 0 and [15:12] is digit 3
load_ready  out  1  shadow register empty; a load is accepted this cycle
binario  out  16  frame-stable value presented to the decoder
selectorMUX  out  2  current digit index, fed to the decoder
digit_blank  out  1  1 = decoder anodes must be forced off
frame_tick  out  1  one-cycle pulse when a frame completes (selector wraps 3 to 0)

Behaviour:
- Reset (rst_n=0, asynchronous) sets these values:
  - prescaler cnt=0, selectorMUX=2'b00
  - binario=16'h0000, shadow=16'h0000, pending=0
  - load_ready=0, digit_blank=1, frame_tick=0, state=IDLE
- All outputs are registered. load_ready rises on the first clk edge after reset release.
- State IDLE (enable=0):
  - cnt is held at 0; selectorMUX is held at its value.
  - digit_blank=1, frame_tick=0.
  - If pending=1, binario<=shadow and pending<=0 on the next edge; there is no frame to tear.
  - Moves to SCAN when enable=1.
- State SCAN (enable=1):
  - cnt counts 0..PRESCALE-1 and wraps.
  - tick occurs when cnt==PRESCALE-1. On tick, selectorMUX<=selectorMUX+1 (mod 4, 3 wraps to 0).
  - digit_blank=1 exactly while the registered cnt < BLANK_CYCLES, else 0. When BLANK_CYCLES=0, digit_blank=0 throughout SCAN.
  - Frame boundary is a tick with selectorMUX==3. On it:
    - frame_tick=1 for exactly the next cycle.
    - If pending=1, binario<=shadow and pending<=0 on the same edge.
  - Goes to IDLE when enable=0, effective on the next edge. cnt clears; selectorMUX is not advanced even if that cycle was a tick.
  - On re-entry to SCAN the held selector starts a full slot (cnt=0).
- Load handshake:
  - load_ready = registered NOT pending.
  - Transfer occurs when load_valid & load_ready at an edge: shadow<=load_data, pending<=1, load_ready<=0.
  - load_valid while load_ready=0 is ignored. The producer must hold or retry; data is not queued.
  - Load transfer and frame-boundary transfer in the same cycle cannot collide, because a transfer requires pending=0 and a frame-boundary update requires pending=1.
  - A value accepted on a frame-boundary edge waits for the next boundary.
- Worst-case latency from accept to binario update is 4*PRESCALE cycles in SCAN, or 1 cycle in IDLE.
- Assertion of rst_n mid-slot or mid-handshake discards the shadow contents immediately.
- No combinational path exists from inputs to outputs.

Test Plan (PRESCALE=4, BLANK_CYCLES=1 unless stated):
1. Reset then enable=1 for 32 cycles -> selectorMUX steps 0,1,2,3,0,... every 4 cycles; digit_blank=1 on the first cycle of each slot; frame_tick pulses every 16 cycles; binario=16'h0000.
2. Load 16'hA3F1 during the slot with selectorMUX=1 -> accepted that edge, load_ready=0; binario becomes 16'hA3F1 on the edge where selectorMUX goes 3 to 0; load_ready returns to 1 one cycle later.
3. Second load 16'h1234 offered while pending -> not accepted, and binario still becomes the first value. The producer holds valid; 16'h1234 is accepted after load_ready=1 and shown one frame later.
4. enable dropped at cnt=2 with selectorMUX=2 -> digit_blank=1 and selectorMUX held at 2. A load of 16'h00FF updates binario one cycle after acceptance. Re-enabling gives a full 4-cycle slot at selector 2.
5. rst_n pulsed low asynchronously (mid-clock) while pending=1 -> all outputs take their reset values immediately; the pending value is never shown.
6. BLANK_CYCLES=0, PRESCALE=2 -> digit_blank=0 throughout SCAN; selector advances every 2 cycles; frame_tick every 8 cycles.
